// File: rtl/ex_cond_flag_stage.sv
// EX-stage output register: holds the NZCV flag register, gates writeback on the op's condition,
// and carries ALU results to EX/MEM through a main slot plus a one-entry skid. Optional: SQUASH_CNT_EN.
module ex_cond_flag_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] result_i,
    input  logic [3:0]        nzcv_i,
    input  logic              set_flags_i,
    input  logic [3:0]        cond_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic              regwrite_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic [RD_W-1:0]   rd_o,
    output logic              regwrite_o,
    output logic              cond_pass_o,
    output logic [3:0]        flags_o
`ifdef SQUASH_CNT_EN
    ,
    output logic [31:0]       squash_cnt_o
`endif
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // ready_o depends only on state, and valid_o/outputs hold while stalled.

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    cond_eval = z;
            4'd1:    cond_eval = ~z;
            4'd2:    cond_eval = cy;
            4'd3:    cond_eval = ~cy;
            4'd4:    cond_eval = n;
            4'd5:    cond_eval = ~n;
            4'd6:    cond_eval = v;
            4'd7:    cond_eval = ~v;
            4'd8:    cond_eval = cy & ~z;
            4'd9:    cond_eval = ~cy | z;
            4'd10:   cond_eval = (n == v);
            4'd11:   cond_eval = (n != v);
            4'd12:   cond_eval = ~z & (n == v);
            4'd13:   cond_eval = z | (n != v);
            4'd14:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_result_q, main_result_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;
    logic              main_rw_q, main_rw_d;
    logic              main_pass_q, main_pass_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_result_q, skid_result_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
    logic              skid_rw_q, skid_rw_d;
    logic              skid_pass_q, skid_pass_d;
    logic [3:0]        flags_q, flags_d;
    logic              accept, drain, pass;

    assign ready_o = ~skid_valid_q;
    assign accept  = valid_i & ready_o;
    assign drain   = main_valid_q & ready_i;
    assign pass    = cond_eval(cond_i, flags_q);

    always_comb begin
        main_valid_d  = main_valid_q;
        main_result_d = main_result_q;
        main_rd_d     = main_rd_q;
        main_rw_d     = main_rw_q;
        main_pass_d   = main_pass_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_rd_d     = skid_rd_q;
        skid_rw_d     = skid_rw_q;
        skid_pass_d   = skid_pass_q;
        flags_d       = flags_q;

        if (accept && set_flags_i && pass) begin
            flags_d = nzcv_i;
        end

        if (skid_valid_q) begin
            // No accept possible here; the skid entry refills main once it drains.
            if (drain) begin
                main_valid_d  = 1'b1;
                main_result_d = skid_result_q;
                main_rd_d     = skid_rd_q;
                main_rw_d     = skid_rw_q;
                main_pass_d   = skid_pass_q;
                skid_valid_d  = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || ready_i) begin
                main_valid_d  = 1'b1;
                main_result_d = result_i;
                main_rd_d     = rd_i;
                main_rw_d     = regwrite_i;
                main_pass_d   = pass;
            end else begin
                skid_valid_d  = 1'b1;
                skid_result_d = result_i;
                skid_rd_d     = rd_i;
                skid_rw_d     = regwrite_i;
                skid_pass_d   = pass;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            main_valid_q  <= 1'b0;
            main_result_q <= '0;
            main_rd_q     <= '0;
            main_rw_q     <= 1'b0;
            main_pass_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            skid_rw_q     <= 1'b0;
            skid_pass_q   <= 1'b0;
            flags_q       <= 4'b0000;
        end else begin
            main_valid_q  <= main_valid_d;
            main_result_q <= main_result_d;
            main_rd_q     <= main_rd_d;
            main_rw_q     <= main_rw_d;
            main_pass_q   <= main_pass_d;
            skid_valid_q  <= skid_valid_d;
            skid_result_q <= skid_result_d;
            skid_rd_q     <= skid_rd_d;
            skid_rw_q     <= skid_rw_d;
            skid_pass_q   <= skid_pass_d;
            flags_q       <= flags_d;
        end
    end

    assign valid_o     = main_valid_q;
    assign result_o    = main_result_q;
    assign rd_o        = main_rd_q;
    assign cond_pass_o = main_valid_q & main_pass_q;
    assign regwrite_o  = main_valid_q & main_rw_q & main_pass_q;
    assign flags_o     = flags_q;

`ifdef SQUASH_CNT_EN
    logic [31:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        squash_cnt_d = squash_cnt_q;
        if (accept && !pass) begin
            squash_cnt_d = squash_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            squash_cnt_q <= 32'd0;
        end else begin
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign squash_cnt_o = squash_cnt_q;
`endif

endmodule
